// File: rtl/fir_sample_serialiser.sv
// Buffers FIR output samples in a small FIFO and streams each one MSB-first with frame sync.
// Build macro PARITY_EN appends an even-parity bit (XOR of all sample bits) to every frame.

module fir_sample_serialiser #(
  parameter int M     = 24,
  parameter int DEPTH = 4,
  parameter int DIV   = 4
) (
  input  logic                   ck,
  input  logic                   rst_n,
  input  logic signed [M-1:0]    in,
  input  logic                   input_ready,
  input  logic                   enable,
  input  logic                   clr_ovf,
  output logic                   sdo,
  output logic                   fs,
  output logic                   bit_strobe,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(M);
  localparam int DW = $clog2(DIV);

`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PARITY, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
`endif

  state_t        state_reg, state_next;
  logic [M-1:0]  shift_reg, shift_next;
  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [DW-1:0] div_reg, div_next;
`ifdef PARITY_EN
  logic          parity_reg, parity_next;
`endif

  logic [M-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          overflow_reg;
  logic          busy_reg;
  logic          pop, push_ok, drop;

  // The LOAD cycle is the only consumer, so a push at full is still accepted then.
  assign pop     = (state_reg == LOAD);
  assign push_ok = input_ready && ((level_reg != LW'(DEPTH)) || pop);
  assign drop    = input_ready && !push_ok;

  always_ff @(posedge ck) begin
    if (push_ok) mem[wr_ptr_reg] <= in;
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (drop)         overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_reg     <= '0;
      busy_reg    <= 1'b0;
`ifdef PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      div_reg     <= div_next;
      busy_reg    <= (state_next != IDLE);
`ifdef PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    div_next     = div_reg;
`ifdef PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if ((level_reg != '0) && enable) state_next = LOAD;
      end
      LOAD: begin
        shift_next   = mem[rd_ptr_reg];
        bit_cnt_next = BW'(M - 1);
        div_next     = '0;
`ifdef PARITY_EN
        parity_next  = 1'b0;
`endif
        state_next   = SHIFT;
      end
      SHIFT: begin
        if (div_reg == DW'(DIV - 1)) begin
          div_next     = '0;
          shift_next   = shift_reg << 1;
          bit_cnt_next = bit_cnt_reg - 1'b1;
`ifdef PARITY_EN
          // Parity accumulates from the bits as they leave, so no second RAM read is needed.
          parity_next  = parity_reg ^ shift_reg[M-1];
          if (bit_cnt_reg == '0) state_next = PARITY;
`else
          if (bit_cnt_reg == '0) state_next = GAP;
`endif
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (div_reg == DW'(DIV - 1)) begin
          div_next   = '0;
          state_next = GAP;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
`endif
      GAP: begin
        if (div_reg == DW'(DIV - 1)) begin
          div_next   = '0;
          state_next = IDLE;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sdo        = 1'b0;
    fs         = 1'b0;
    bit_strobe = 1'b0;
    case (state_reg)
      SHIFT: begin
        sdo        = shift_reg[M-1];
        fs         = (bit_cnt_reg == BW'(M - 1));
        bit_strobe = (div_reg == '0);
      end
`ifdef PARITY_EN
      PARITY: begin
        sdo        = parity_reg;
        bit_strobe = (div_reg == '0);
      end
`endif
      default: ;
    endcase
  end

  assign busy     = busy_reg;
  assign overflow = overflow_reg;
  assign level    = level_reg;

endmodule

// File: tb/tb_fir_sample_serialiser.sv
// Bench for fir_sample_serialiser: directed scenarios then random traffic, every cycle compared
// against a frame-position reference model built from queue arithmetic.

module tb_fir_sample_serialiser;
  localparam int M     = 24;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
`ifdef PARITY_EN
  localparam int NB = M + 1;
`else
  localparam int NB = M;
`endif
  localparam int FRAME = 1 + NB * DIV + DIV;

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic [M-1:0] in_s = '0;
  logic         input_ready = 1'b0;
  logic         enable = 1'b0;
  logic         clr_ovf = 1'b0;
  logic         sdo, fs, bit_strobe, busy, overflow;
  logic [$clog2(DEPTH):0] level;

  fir_sample_serialiser #(.M(M), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .ck(ck), .rst_n(rst_n), .in(in_s), .input_ready(input_ready), .enable(enable),
    .clr_ovf(clr_ovf), .sdo(sdo), .fs(fs), .bit_strobe(bit_strobe), .busy(busy),
    .overflow(overflow), .level(level)
  );

  always #5 ck = ~ck;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, frame as a position counter (0 = load cycle).
  logic [M-1:0] mq[$];
  bit           m_ovf = 0;
  bit           m_act = 0;
  int           m_pos = 0;
  logic [M-1:0] m_cur = '0;

  int           busy_cnt = 0;
  int           strobe_cnt = 0;
  logic [M-1:0] rx = '0;
  int           rx_bits = 0;
  int           frames = 0;

  task automatic model_edge();
    bit pop_now, start_now;
    int sz;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0;
      m_act = 0;
      m_pos = 0;
      return;
    end
    sz        = mq.size();
    pop_now   = m_act && (m_pos == 0);
    start_now = !m_act && (sz > 0) && enable;
    if (pop_now) m_cur = mq.pop_front();
    if (input_ready) begin
      if (sz < DEPTH || pop_now) mq.push_back(in_s);
      else m_ovf = 1;
    end else if (clr_ovf) begin
      m_ovf = 0;
    end
    if (input_ready && clr_ovf && (sz < DEPTH || pop_now)) m_ovf = 0;
    if (m_act) begin
      if (m_pos == FRAME - 1) m_act = 0;
      else m_pos++;
    end else if (start_now) begin
      m_act = 1;
      m_pos = 0;
    end
  endtask

  task automatic step();
    logic e_sdo, e_fs, e_stb;
    int k;
    @(posedge ck);
    model_edge();
    @(negedge ck);
    e_sdo = 1'b0;
    e_fs  = 1'b0;
    e_stb = 1'b0;
    if (m_act && m_pos >= 1 && m_pos <= M * DIV) begin
      k     = (m_pos - 1) / DIV;
      e_sdo = m_cur[M-1-k];
      e_fs  = (k == 0);
      e_stb = ((m_pos - 1) % DIV == 0);
    end else if (m_act && NB > M && m_pos > M * DIV && m_pos <= NB * DIV) begin
      e_sdo = ^m_cur;
      e_stb = (m_pos == M * DIV + 1);
    end
    check("sdo", 32'(sdo), 32'(e_sdo));
    check("fs", 32'(fs), 32'(e_fs));
    check("bit_strobe", 32'(bit_strobe), 32'(e_stb));
    check("busy", 32'(busy), 32'(m_act));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("level", 32'(level), 32'(mq.size()));
    busy_cnt   += int'(busy);
    strobe_cnt += int'(bit_strobe);
    // Reassemble each serial word; fs marks the MSB so the decoder resyncs after any abort.
    if (!rst_n) begin
      rx_bits = 0;
    end else if (bit_strobe) begin
      if (fs) rx_bits = 0;
      if (rx_bits < M) begin
        rx = {rx[M-2:0], sdo};
        rx_bits++;
        if (rx_bits == M) begin
          frames++;
          check("frame_word", 32'(rx), 32'(m_cur));
          $display("frame %0d rx=%06h model=%06h level=%0d", frames, rx, m_cur, level);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [M-1:0] v);
    in_s        = v;
    input_ready = 1'b1;
    step();
    input_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  int lat;

  initial begin
    // 1: single sample, latency, frame length and strobe count
    do_reset();
    check("reset_level", 32'(level), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    enable     = 1'b1;
    busy_cnt   = 0;
    strobe_cnt = 0;
    push(24'h800001);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (fs && lat == 0) lat = i;
    end
    // Edges after the push edge: one to reach LOAD, one more to present the MSB.
    check("msb_latency", 32'(lat), 32'd2);
    idle(FRAME + 10);
    check("busy_cycles", 32'(busy_cnt), 32'(FRAME));
    check("strobe_count", 32'(strobe_cnt), 32'(NB));

    // 2: overflow with the line held off, then drain and clear
    enable = 1'b0;
    for (int v = 1; v <= 6; v++) push(M'(v));
    step();
    check("ovf_level", 32'(level), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    enable = 1'b1;
    idle(DEPTH * (FRAME + 1) + 10);
    check("drained_level", 32'(level), 32'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // 3: push on the exact LOAD cycle while full
    enable = 1'b0;
    for (int v = 0; v < DEPTH; v++) push(M'(24'h100 + v));
    enable = 1'b1;
    step();
    push(24'h00ABCD);
    check("full_pushpop_level", 32'(level), 32'(DEPTH));
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    idle((DEPTH + 1) * (FRAME + 1) + 10);

    // 4: reset during bit 10 with two samples queued
    push(24'h5A5A5A);
    push(24'h123456);
    push(24'h654321);
    idle(1 + 10 * DIV);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_sdo", 32'(sdo), 32'd0);
    check("rst_mid_fs", 32'(fs), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_level", 32'(level), 32'd0);
    busy_cnt = 0;
    idle(2 * FRAME);
    check("rst_no_frames", 32'(busy_cnt), 32'd0);

    // 5: enable dropped during bit 5 with one sample queued
    push(24'hC0FFEE);
    push(24'h0BEEF0);
    idle(2 + 5 * DIV);
    enable = 1'b0;
    idle(FRAME + 20);
    check("hold_level", 32'(level), 32'd1);
    check("hold_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    idle(FRAME + 10);
    check("hold_drained", 32'(level), 32'd0);

    // 6: parity patterns (plain frames when the parity bit is not built in)
    busy_cnt = 0;
    push(24'h000003);
    idle(FRAME + 5);
    push(24'h000001);
    idle(FRAME + 5);
    check("two_frame_busy", 32'(busy_cnt), 32'(2 * FRAME));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      in_s        = M'($urandom);
      input_ready = ($urandom_range(0, 29) == 0);
      clr_ovf     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      rst_n       = ($urandom_range(0, 999) != 0);
      step();
    end
    input_ready = 1'b0;
    clr_ovf     = 1'b0;
    rst_n       = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
